sha256_round_ctrl: RTL

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_round_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round controller: sequences INIT, ROUNDS compression rounds, hash update and done.
// Optional feature: define SHA_ROUND_STALL_EN to add the stall input that freezes round progress.
module sha256_round_ctrl #(
   parameter int unsigned ROUNDS = 64
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
`ifdef SHA_ROUND_STALL_EN
   input  logic       stall,
`endif
   output logic       busy,
   output logic       init_en,
   output logic       reg_en,
   output logic [5:0] round_idx,
   output logic       w_sel,
   output logic [3:0] w_addr,
   output logic       hash_upd,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ROUND = 3'd2,
      FINAL = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [5:0] LAST_IDX      = 6'(ROUNDS - 1);
   localparam logic [5:0] FIRST_EXP_IDX = 6'd16;

   state_t     state_q, state_d;
   logic [5:0] round_idx_q, round_idx_d;
   logic       busy_q, busy_d;
   logic       init_en_q, init_en_d;
   logic       reg_en_q, reg_en_d;
   logic       w_sel_q, w_sel_d;
   logic       hash_upd_q, hash_upd_d;
   logic       done_q, done_d;
   logic       stall_s;

`ifdef SHA_ROUND_STALL_EN
   assign stall_s = stall;
`else
   assign stall_s = 1'b0;
`endif

   // Next state, round index and the output values for the upcoming cycle.
   always_comb begin
      state_d     = state_q;
      round_idx_d = round_idx_q;
      case (state_q)
         IDLE: begin
            round_idx_d = 6'd0;
            if (start) begin
               state_d = INIT;
            end else begin
               state_d = IDLE;
            end
         end
         INIT: begin
            state_d     = ROUND;
            round_idx_d = 6'd0;
         end
         ROUND: begin
            if (stall_s) begin
               state_d = ROUND;
            end else if (round_idx_q == LAST_IDX) begin
               state_d = FINAL;
            end else begin
               round_idx_d = round_idx_q + 6'd1;
            end
         end
         FINAL: begin
            state_d = DONE;
         end
         DONE: begin
            state_d     = IDLE;
            round_idx_d = 6'd0;
         end
         default: begin
            state_d     = IDLE;
            round_idx_d = 6'd0;
         end
      endcase

      // A stalled ROUND cycle becomes a bubble: index held, working registers not loaded.
      busy_d     = (state_d != IDLE);
      init_en_d  = (state_d == INIT);
      reg_en_d   = (state_d == ROUND) && !((state_q == ROUND) && stall_s);
      w_sel_d    = (state_d == ROUND) && (round_idx_d >= FIRST_EXP_IDX);
      hash_upd_d = (state_d == FINAL);
      done_d     = (state_d == DONE);
   end

   // State and registered output flops; reset aborts any block in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         round_idx_q <= 6'd0;
         busy_q      <= 1'b0;
         init_en_q   <= 1'b0;
         reg_en_q    <= 1'b0;
         w_sel_q     <= 1'b0;
         hash_upd_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         round_idx_q <= round_idx_d;
         busy_q      <= busy_d;
         init_en_q   <= init_en_d;
         reg_en_q    <= reg_en_d;
         w_sel_q     <= w_sel_d;
         hash_upd_q  <= hash_upd_d;
         done_q      <= done_d;
      end
   end

   assign busy      = busy_q;
   assign init_en   = init_en_q;
   assign reg_en    = reg_en_q;
   assign round_idx = round_idx_q;
   assign w_sel     = w_sel_q;
   assign w_addr    = round_idx_q[3:0];
   assign hash_upd  = hash_upd_q;
   assign done      = done_q;

endmodule
